// File: rtl/tlvds_ddr_rx.sv
`default_nettype none
// ============================================================================
// Module   : tlvds_ddr_rx
// Brief    : DDR serial receiver with sync-word framing (hunt/verify/lock).
// Revision : 1.0
// ============================================================================
module tlvds_ddr_rx #(
  parameter logic [7:0] SYNC_WORD  = 8'hBC,
  parameter int         FRAME_LEN  = 16,
  parameter int         LOCK_COUNT = 2,
  parameter int         MISS_LIMIT = 3
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       tlvds_p,
  input  logic       tlvds_n,
  output logic [7:0] data_out,
  output logic       data_valid,
  output logic       sof,
  output logic       locked,
  output logic       sync_err
);

  typedef enum logic [1:0] {
    S_HUNT   = 2'd0,
    S_VERIFY = 2'd1,
    S_LOCKED = 2'd2
  } state_t;

  localparam logic [7:0] c_LAST_SLOT = 8'(FRAME_LEN - 1);
  localparam logic [7:0] c_LOCK_CNT  = 8'(LOCK_COUNT);
  localparam logic [7:0] c_MISS_LIM  = 8'(MISS_LIMIT);

  // Differential input buffer and IDDR: Q0 is the bit sampled on the falling
  // edge (earlier), Q1 the bit sampled on the following rising edge (later).
  logic w_rx;
  logic r_neg, r_q0, r_q1;

  assign w_rx = tlvds_p & ~tlvds_n;

  always_ff @(negedge clk or posedge rst) begin
    if (rst) r_neg <= 1'b0;
    else     r_neg <= w_rx;
  end

  state_t     r_state, w_state;
  logic [8:0] r_sr;
  logic       r_offset, w_offset;
  logic [1:0] r_phase, w_phase;
  logic [7:0] r_bcnt, w_bcnt;
  logic [7:0] r_vcnt, w_vcnt;
  logic [7:0] r_mcnt, w_mcnt;
  logic [7:0] w_dout;
  logic       w_dv, w_sof, w_err;
  logic [7:0] w_byte, w_slot;
  logic       w_bnd, w_match;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_q0       <= 1'b0;
      r_q1       <= 1'b0;
      r_sr       <= '0;
      r_state    <= S_HUNT;
      r_offset   <= 1'b0;
      r_phase    <= '0;
      r_bcnt     <= '0;
      r_vcnt     <= '0;
      r_mcnt     <= '0;
      data_out   <= '0;
      data_valid <= 1'b0;
      sof        <= 1'b0;
      sync_err   <= 1'b0;
    end else begin
      r_q0       <= r_neg;
      r_q1       <= w_rx;
      r_sr       <= {r_sr[6:0], r_q0, r_q1};
      r_state    <= w_state;
      r_offset   <= w_offset;
      r_phase    <= w_phase;
      r_bcnt     <= w_bcnt;
      r_vcnt     <= w_vcnt;
      r_mcnt     <= w_mcnt;
      data_out   <= w_dout;
      data_valid <= w_dv;
      sof        <= w_sof;
      sync_err   <= w_err;
    end
  end

  always_comb begin
    w_state  = r_state;
    w_offset = r_offset;
    w_phase  = r_phase + 2'd1;
    w_vcnt   = r_vcnt;
    w_mcnt   = r_mcnt;
    w_dout   = data_out;
    w_dv     = 1'b0;
    w_sof    = 1'b0;
    w_err    = 1'b0;
    w_byte   = r_offset ? r_sr[8:1] : r_sr[7:0];
    w_match  = (w_byte == SYNC_WORD);
    w_bnd    = (r_phase == 2'd3);
    w_slot   = (r_bcnt == c_LAST_SLOT) ? 8'd0 : r_bcnt + 8'd1;
    w_bcnt   = w_bnd ? w_slot : r_bcnt;

    case (r_state)
      S_HUNT: begin
        w_phase = '0;
        w_bcnt  = '0;
        w_vcnt  = '0;
        w_mcnt  = '0;
        // Both alignments may match at once; the Q1-ending window takes priority.
        if (r_sr[7:0] == SYNC_WORD) begin
          w_offset = 1'b0;
          w_state  = S_VERIFY;
        end else if (r_sr[8:1] == SYNC_WORD) begin
          w_offset = 1'b1;
          w_state  = S_VERIFY;
        end
      end
      S_VERIFY: begin
        if (w_bnd && w_slot == 8'd0) begin
          if (!w_match) begin
            w_state = S_HUNT;
            w_vcnt  = '0;
          end else if (r_vcnt + 8'd1 == c_LOCK_CNT) begin
            w_state = S_LOCKED;
            w_vcnt  = '0;
            w_mcnt  = '0;
          end else begin
            w_vcnt = r_vcnt + 8'd1;
          end
        end
      end
      S_LOCKED: begin
        if (w_bnd) begin
          if (w_slot == 8'd0) begin
            if (w_match) begin
              w_mcnt = '0;
            end else begin
              w_err = 1'b1;
              if (r_mcnt + 8'd1 == c_MISS_LIM) begin
                w_state = S_HUNT;
                w_mcnt  = '0;
              end else begin
                w_mcnt = r_mcnt + 8'd1;
              end
            end
          end else begin
            w_dv   = 1'b1;
            w_dout = w_byte;
            w_sof  = (w_slot == 8'd1);
          end
        end
      end
      default: w_state = S_HUNT;
    endcase
  end

  assign locked = (r_state == S_LOCKED);

endmodule
`default_nettype wire

// File: doc/tlvds_ddr_rx.md
TLVDS_DDR_RX -- requirements
Module: tlvds_ddr_rx

Interface
REQ-001 Parameter SYNC_WORD, default 8'hBC: frame sync byte, sent MSB first.
REQ-002 Parameter FRAME_LEN, default 16: bytes per frame including the sync byte; legal range 2..256.
REQ-003 Parameter LOCK_COUNT, default 2: consecutive correctly spaced syncs needed after the first sync before lock.
REQ-004 Parameter MISS_LIMIT, default 3: consecutive missed syncs in LOCKED that cause a return to HUNT.
REQ-005 clk  input  1  sole clock; also clocks the internal IDDR.
REQ-006 rst  input  1  reset, asynchronous, active-high.
REQ-007 tlvds_p  input  1  differential pair, positive leg.
REQ-008 tlvds_n  input  1  differential pair, negative leg.
REQ-009 data_out  output  8  last captured payload byte.
REQ-010 data_valid  output  1  one-cycle strobe; data_out holds a new payload byte.
REQ-011 sof  output  1  one-cycle strobe, coincident with data_valid on the first payload byte of a frame.
REQ-012 locked  output  1  high while in state LOCKED.
REQ-013 sync_err  output  1  one-cycle strobe on each missed sync while LOCKED.

Function
REQ-014 The pair SHALL enter through one TLVDS_IBUF (I=tlvds_p, IB=tlvds_n) feeding one IDDR clocked by clk; Q0 is the earlier bit in time, Q1 the later.
REQ-015 Each cycle, the 9-bit shift register sr SHALL update as sr <= {sr[6:0], Q0, Q1}.
REQ-016 Candidate windows after the shift: W0 = sr[7:0] (byte ends on Q1), W1 = sr[8:1] (byte ends on Q0).
REQ-017 States SHALL be HUNT, VERIFY and LOCKED, with a 1-bit offset register, a 2-bit phase counter, an 8-bit byte counter, a verify counter and a miss counter.
REQ-018 HUNT: W0==SYNC_WORD SHALL capture offset=0; otherwise W1==SYNC_WORD SHALL capture offset=1; either case SHALL clear phase and byte count and go to VERIFY.
REQ-019 If W0 and W1 both match in the same cycle, offset=0 SHALL win.
REQ-020 Outside HUNT, phase SHALL increment every cycle modulo 4; a byte boundary occurs at phase==3, with the byte taken from W[offset].
REQ-021 The byte counter SHALL increment at each byte boundary and wrap from FRAME_LEN-1 to 0; count 0 is the expected sync slot.
REQ-022 VERIFY: a matching byte at the sync slot SHALL increment the verify count; on reaching LOCK_COUNT the state SHALL go to LOCKED.
REQ-023 VERIFY: a mismatch at the sync slot SHALL return to HUNT and clear the verify count.
REQ-024 VERIFY: no data_valid, sof or sync_err SHALL be produced.
REQ-025 LOCKED: each byte at a non-sync slot SHALL load data_out and pulse data_valid the following cycle; the byte at slot 1 SHALL also pulse sof.
REQ-026 LOCKED: a mismatch at the sync slot SHALL pulse sync_err, increment the miss count and keep timing; a match SHALL clear the miss count.
REQ-027 LOCKED: the miss count reaching MISS_LIMIT SHALL drop locked, go to HUNT in the same cycle and suppress all payload output for that frame position.
REQ-028 Payload bytes equal to SYNC_WORD SHALL be delivered as data and SHALL NOT realign the receiver.
REQ-029 Latency: data_valid SHALL assert exactly one clk after the byte-boundary cycle whose window holds the last bit of that byte.
REQ-030 locked SHALL assert in the cycle after the LOCK_COUNT-th confirming sync is detected.

Reset
REQ-031 While rst is high: state HUNT; sr, offset, phase, all counters and data_out = 0; data_valid, sof, locked, sync_err = 0.
REQ-032 rst asserted mid-frame SHALL take effect immediately and discard any partial byte; after release, sync search SHALL restart from an empty shift register.

Verification
REQ-033 Stream of 8'hBC followed by 15 payload bytes 8'h00..8'h0E, repeated, aligned to Q0 -> lock after 3 syncs; then 15 data_valid per frame; sof coincides with 8'h00.
REQ-034 Same stream delayed by one bit (sync ending on Q0) -> lock with offset=1; identical payload sequence.
REQ-035 Locked link, one corrupted sync byte (8'hBD) -> one sync_err pulse; locked stays 1; payload uninterrupted.
REQ-036 Three consecutive corrupted syncs -> three sync_err pulses; locked falls after the third; no data_valid until relock.
REQ-037 Payload containing 8'hBC at slot 5 -> delivered on data_out with data_valid; no realignment.
REQ-038 rst pulsed for 1 cycle mid-payload while locked -> all outputs 0 immediately; relock after 3 further syncs.
